// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal_sync RF arbiter: response codes, slot states and the
// verdict-to-response priority decode.
package fractal_sync_pkg;

  localparam int unsigned SD_WIDTH = 4;

  typedef enum logic [2:0] {
    RSP_STORED = 3'd0,
    RSP_DONE   = 3'd1,
    RSP_BYPASS = 3'd2,
    RSP_IGNORE = 3'd3,
    RSP_ERR    = 3'd4
  } rf_rsp_e;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_PEND,
    SLOT_RESP
  } arb_slot_e;

  // Error dominates, then same-cycle duplicates, then a completed barrier.
  function automatic rf_rsp_e rf_rsp_decode(input logic present, input logic id_err,
                                            input logic bypass, input logic ignore);
    rf_rsp_e rsp;
    if (id_err) begin
      rsp = RSP_ERR;
    end else if (ignore) begin
      rsp = RSP_IGNORE;
    end else if (bypass) begin
      rsp = RSP_BYPASS;
    end else if (present) begin
      rsp = RSP_DONE;
    end else begin
      rsp = RSP_STORED;
    end
    return rsp;
  endfunction

endpackage

// File: rtl/fractal_sync_rr_multi_grant.sv
// Combinational round-robin selector granting up to N_PORTS pending slots per cycle,
// scanning upward from rr_ptr_i and mapping the k-th hit onto port k.
module fractal_sync_rr_multi_grant #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned N_PORTS = 2
) (
  input  logic [N_REQ-1:0]                           pend_i,
  input  logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] rr_ptr_i,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] port_idx_o [N_PORTS],
  output logic [N_PORTS-1:0]                         port_valid_o,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] rr_ptr_next_o
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  int unsigned     slot;
  logic [IdxW-1:0] slot_idx;
  logic            taken;

  always_comb begin
    slot          = '0;
    slot_idx      = '0;
    taken         = 1'b0;
    port_valid_o  = '0;
    rr_ptr_next_o = rr_ptr_i;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      port_idx_o[p] = '0;
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      slot = 32'(rr_ptr_i) + i;
      if (slot >= N_REQ) begin
        slot = slot - N_REQ;
      end
      slot_idx = IdxW'(slot);
      taken    = 1'b0;
      // Ports fill in ascending order; a slot takes the first free one.
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (pend_i[slot_idx] && !taken && !port_valid_o[p]) begin
          port_valid_o[p] = 1'b1;
          port_idx_o[p]   = slot_idx;
          taken           = 1'b1;
        end
      end
      if (taken) begin
        rr_ptr_next_o = (slot_idx == IdxW'(N_REQ - 1)) ? '0 : slot_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fractal_sync_rf_arbiter.sv
// Shares the RF check ports among N_REQ requesters with per-slot request/response handshakes.
// Optional grant/conflict counters are enabled by defining FRACTAL_SYNC_RF_ARB_PERF_EN.
module fractal_sync_rf_arbiter
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned N_PORTS  = 2,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic [ID_WIDTH-1:0] req_id_i     [N_REQ],
  input  logic [SD_WIDTH-1:0] req_sd_i     [N_REQ],
  output logic [N_REQ-1:0]    rsp_valid_o,
  input  logic [N_REQ-1:0]    rsp_ready_i,
  output rf_rsp_e             rsp_type_o   [N_REQ],
  output logic [SD_WIDTH-1:0] rsp_sd_o     [N_REQ],
  output logic [N_PORTS-1:0]  rf_check_o,
  output logic [ID_WIDTH-1:0] rf_id_o      [N_PORTS],
  output logic [SD_WIDTH-1:0] rf_sd_o      [N_PORTS],
  input  logic [N_PORTS-1:0]  rf_present_i,
  input  logic [N_PORTS-1:0]  rf_id_err_i,
  input  logic [N_PORTS-1:0]  rf_bypass_i,
  input  logic [N_PORTS-1:0]  rf_ignore_i,
`ifdef FRACTAL_SYNC_RF_ARB_PERF_EN
  output logic [31:0]         grant_cnt_o,
  output logic [31:0]         conflict_cnt_o,
`endif
  input  logic [SD_WIDTH-1:0] rf_sd_i      [N_PORTS]
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_slot_e           slot_q     [N_REQ];
  logic [ID_WIDTH-1:0] id_q       [N_REQ];
  logic [SD_WIDTH-1:0] sd_q       [N_REQ];
  rf_rsp_e             rsp_type_q [N_REQ];
  logic [SD_WIDTH-1:0] rsp_sd_q   [N_REQ];
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0]    pend;
  logic [N_REQ-1:0]    grant;
  logic [IdxW-1:0]     port_idx   [N_PORTS];
  logic [N_PORTS-1:0]  port_valid;
  rf_rsp_e             port_type  [N_PORTS];
  logic [SD_WIDTH-1:0] port_sd    [N_PORTS];
  rf_rsp_e             cap_type   [N_REQ];
  logic [SD_WIDTH-1:0] cap_sd     [N_REQ];

  fractal_sync_rr_multi_grant #(
    .N_REQ   (N_REQ),
    .N_PORTS (N_PORTS)
  ) u_rr_multi_grant (
    .pend_i        (pend),
    .rr_ptr_i      (rr_ptr_q),
    .port_idx_o    (port_idx),
    .port_valid_o  (port_valid),
    .rr_ptr_next_o (rr_ptr_d)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pend[i]        = (slot_q[i] == SLOT_PEND);
      req_ready_o[i] = (slot_q[i] == SLOT_IDLE);
      rsp_valid_o[i] = (slot_q[i] == SLOT_RESP);
      rsp_type_o[i]  = rsp_valid_o[i] ? rsp_type_q[i] : RSP_STORED;
      rsp_sd_o[i]    = rsp_valid_o[i] ? rsp_sd_q[i] : '0;
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      rf_check_o[p] = port_valid[p];
      rf_id_o[p]    = port_valid[p] ? id_q[port_idx[p]] : '0;
      rf_sd_o[p]    = port_valid[p] ? sd_q[port_idx[p]] : '0;
      port_type[p]  = rf_rsp_decode(rf_present_i[p], rf_id_err_i[p], rf_bypass_i[p],
                                    rf_ignore_i[p]);
      port_sd[p]    = (port_type[p] == RSP_DONE) ? rf_sd_i[p] : '0;
    end
  end

  // Route each port's verdict back to the slot that owns it this cycle.
  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cap_type[i] = RSP_STORED;
      cap_sd[i]   = '0;
    end
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (port_valid[p] && (port_idx[p] == IdxW'(i))) begin
          grant[i]    = 1'b1;
          cap_type[i] = port_type[p];
          cap_sd[i]   = port_sd[p];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        slot_q[i]     <= SLOT_IDLE;
        id_q[i]       <= '0;
        sd_q[i]       <= '0;
        rsp_type_q[i] <= RSP_STORED;
        rsp_sd_q[i]   <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        unique case (slot_q[i])
          SLOT_IDLE: begin
            if (req_valid_i[i]) begin
              slot_q[i] <= SLOT_PEND;
              id_q[i]   <= req_id_i[i];
              sd_q[i]   <= req_sd_i[i];
            end
          end
          SLOT_PEND: begin
            if (grant[i]) begin
              slot_q[i]     <= SLOT_RESP;
              rsp_type_q[i] <= cap_type[i];
              rsp_sd_q[i]   <= cap_sd[i];
            end
          end
          SLOT_RESP: begin
            if (rsp_ready_i[i]) begin
              slot_q[i] <= SLOT_IDLE;
            end
          end
          default: slot_q[i] <= SLOT_IDLE;
        endcase
      end
    end
  end

`ifdef FRACTAL_SYNC_RF_ARB_PERF_EN
  logic [31:0] grant_cnt_q, conflict_cnt_q;
  logic [32:0] grant_sum, conflict_sum;

  always_comb begin
    grant_sum    = {1'b0, grant_cnt_q};
    conflict_sum = {1'b0, conflict_cnt_q};
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      grant_sum    = grant_sum + 33'(port_valid[p]);
      conflict_sum = conflict_sum + 33'(port_valid[p] && (port_type[p] == RSP_BYPASS));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt_q    <= grant_sum[32] ? '1 : grant_sum[31:0];
      conflict_cnt_q <= conflict_sum[32] ? '1 : conflict_sum[31:0];
    end
  end

  assign grant_cnt_o    = grant_cnt_q;
  assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_fractal_sync_rf_arbiter.sv
// Bench for fractal_sync_rf_arbiter: a small RF model answers the check ports, and a
// scoreboard queue holds the response each slot is owed.
module tb_fractal_sync_rf_arbiter;
  import fractal_sync_pkg::*;

  localparam int unsigned N_REQ    = 4;
  localparam int unsigned N_PORTS  = 2;
  localparam int unsigned ID_WIDTH = 2;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [N_REQ-1:0]    req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [ID_WIDTH-1:0] req_id_i [N_REQ];
  logic [SD_WIDTH-1:0] req_sd_i [N_REQ];
  rf_rsp_e             rsp_type_o [N_REQ];
  logic [SD_WIDTH-1:0] rsp_sd_o [N_REQ];
  logic [N_PORTS-1:0]  rf_check_o, rf_present_i, rf_id_err_i, rf_bypass_i, rf_ignore_i;
  logic [ID_WIDTH-1:0] rf_id_o [N_PORTS];
  logic [SD_WIDTH-1:0] rf_sd_o [N_PORTS];
  logic [SD_WIDTH-1:0] rf_sd_i [N_PORTS];
`ifdef FRACTAL_SYNC_RF_ARB_PERF_EN
  logic [31:0]         grant_cnt_o, conflict_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  fractal_sync_rf_arbiter #(
    .N_REQ    (N_REQ),
    .N_PORTS  (N_PORTS),
    .ID_WIDTH (ID_WIDTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_id_i       (req_id_i),
    .req_sd_i       (req_sd_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_type_o     (rsp_type_o),
    .rsp_sd_o       (rsp_sd_o),
    .rf_check_o     (rf_check_o),
    .rf_id_o        (rf_id_o),
    .rf_sd_o        (rf_sd_o),
    .rf_present_i   (rf_present_i),
    .rf_id_err_i    (rf_id_err_i),
    .rf_bypass_i    (rf_bypass_i),
    .rf_ignore_i    (rf_ignore_i),
`ifdef FRACTAL_SYNC_RF_ARB_PERF_EN
    .grant_cnt_o    (grant_cnt_o),
    .conflict_cnt_o (conflict_cnt_o),
`endif
    .rf_sd_i        (rf_sd_i)
  );

  // RF model: id 3 is out of range; a barrier completes on its second arrival.
  logic                tbl_v  [4];
  logic [SD_WIDTH-1:0] tbl_sd [4];
  logic [N_PORTS-1:0]  m_store, m_clear;
  logic                dup_lo, dup_hi;

  always_comb begin
    rf_present_i = '0;
    rf_id_err_i  = '0;
    rf_bypass_i  = '0;
    rf_ignore_i  = '0;
    m_store      = '0;
    m_clear      = '0;
    dup_lo       = 1'b0;
    dup_hi       = 1'b0;
    for (int p = 0; p < N_PORTS; p++) rf_sd_i[p] = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (rf_check_o[p]) begin
        dup_lo = 1'b0;
        dup_hi = 1'b0;
        for (int q = 0; q < N_PORTS; q++) begin
          if (q != p && rf_check_o[q] && rf_id_o[q] == rf_id_o[p]) begin
            if (q > p) dup_lo = 1'b1;
            else       dup_hi = 1'b1;
          end
        end
        if (rf_id_o[p] == 2'd3) rf_id_err_i[p] = 1'b1;
        else if (dup_hi)        rf_ignore_i[p] = 1'b1;
        else if (dup_lo)        rf_bypass_i[p] = 1'b1;
        else if (tbl_v[rf_id_o[p]]) begin
          rf_present_i[p] = 1'b1;
          rf_sd_i[p]      = tbl_sd[rf_id_o[p]];
          m_clear[p]      = 1'b1;
        end else begin
          m_store[p] = 1'b1;
        end
      end
    end
  end

  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) tbl_v[i] <= 1'b0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (m_clear[p]) begin
          tbl_v[rf_id_o[p]] <= 1'b0;
        end else if (m_store[p]) begin
          tbl_v[rf_id_o[p]]  <= 1'b1;
          tbl_sd[rf_id_o[p]] <= rf_sd_o[p];
        end
      end
    end
  end

  typedef struct {
    int                  slot;
    rf_rsp_e             typ;
    logic [SD_WIDTH-1:0] sd;
  } exp_t;

  typedef struct {
    logic [1:0]          slot;
    logic [1:0]          id;
    logic [SD_WIDTH-1:0] sd;
    rf_rsp_e             typ;
    logic [SD_WIDTH-1:0] esd;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs [7];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: each handshaken response is matched to the oldest expectation for its slot.
  always @(negedge clk_i) begin
    int idx;
    if (!rst_i) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (rsp_valid_o[i] && rsp_ready_i[i]) begin
          idx = -1;
          for (int j = 0; j < sb_q.size(); j++) begin
            if (idx < 0 && sb_q[j].slot == i) idx = j;
          end
          if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp slot %0d: got type %0d, required no response", i,
                     rsp_type_o[i]);
          end else begin
            check($sformatf("rsp_type[%0d]", i), 32'(rsp_type_o[i]), 32'(sb_q[idx].typ));
            check($sformatf("rsp_sd[%0d]", i), 32'(rsp_sd_o[i]), 32'(sb_q[idx].sd));
            sb_q.delete(idx);
          end
        end
      end
    end
  end

  task automatic single_req(input logic [1:0] slot, input logic [1:0] id,
                            input logic [SD_WIDTH-1:0] sd, input rf_rsp_e typ,
                            input logic [SD_WIDTH-1:0] esd);
    check("ready_before_req", 32'(req_ready_o[slot]), 32'd1);
    req_valid_i[slot] = 1'b1;
    req_id_i[slot]    = id;
    req_sd_i[slot]    = sd;
    sb_q.push_back('{int'(slot), typ, esd});
    tick();
    req_valid_i[slot] = 1'b0;
    @(negedge clk_i);
    check("single_check_vec", 32'(rf_check_o), 32'b01);
    check("single_rf_id", 32'(rf_id_o[0]), 32'(id));
    check("single_rf_sd", 32'(rf_sd_o[0]), 32'(sd));
    check("single_ready_pend", 32'(req_ready_o[slot]), 32'd0);
    check("single_no_early_rsp", 32'(rsp_valid_o[slot]), 32'd0);
    tick();
    @(negedge clk_i);
    check("single_rsp_latency", 32'(rsp_valid_o[slot]), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = '1;
    rsp_ready_i = '1;
    for (int i = 0; i < N_REQ; i++) begin
      req_id_i[i] = '0;
      req_sd_i[i] = '0;
    end

    vecs[0] = '{2'd1, 2'd2, 4'd3, RSP_STORED, 4'd0};
    vecs[1] = '{2'd2, 2'd2, 4'd5, RSP_DONE,   4'd3};
    vecs[2] = '{2'd0, 2'd0, 4'd7, RSP_STORED, 4'd0};
    vecs[3] = '{2'd3, 2'd0, 4'd1, RSP_DONE,   4'd7};
    vecs[4] = '{2'd2, 2'd3, 4'd2, RSP_ERR,    4'd0};
    vecs[5] = '{2'd0, 2'd1, 4'd4, RSP_STORED, 4'd0};
    vecs[6] = '{2'd1, 2'd1, 4'd9, RSP_DONE,   4'd4};

    // Reset held two cycles with every request valid.
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk_i);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      check("rst_rf_check", 32'(rf_check_o), 32'h0);
      check("rst_req_ready", 32'(req_ready_o), 32'hf);
    end
    tick();
    rst_i       = 1'b0;
    req_valid_i = '0;
    @(negedge clk_i);
    check("post_rst_ready", 32'(req_ready_o), 32'hf);
    check("post_rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    tick();

    // All four pending from rr_ptr 0: slots 0,1 first, then 2,3.
    for (int i = 0; i < N_REQ; i++) req_id_i[i] = 2'(i % 2);
    for (int i = 0; i < N_REQ; i++) req_sd_i[i] = 4'(i + 1);
    req_valid_i = '1;
    sb_q.push_back('{0, RSP_STORED, 4'd0});
    sb_q.push_back('{1, RSP_STORED, 4'd0});
    sb_q.push_back('{2, RSP_DONE,   4'd1});
    sb_q.push_back('{3, RSP_DONE,   4'd2});
    tick();
    req_valid_i = '0;
    @(negedge clk_i);
    check("rr_a_check", 32'(rf_check_o), 32'b11);
    check("rr_a_port0_sd", 32'(rf_sd_o[0]), 32'd1);
    check("rr_a_port1_sd", 32'(rf_sd_o[1]), 32'd2);
    tick();
    @(negedge clk_i);
    check("rr_b_check", 32'(rf_check_o), 32'b11);
    check("rr_b_port0_sd", 32'(rf_sd_o[0]), 32'd3);
    check("rr_b_port1_sd", 32'(rf_sd_o[1]), 32'd4);
    check("rr_b_rsp_valid", 32'(rsp_valid_o), 32'b0011);
    tick();
    @(negedge clk_i);
    check("rr_c_rsp_valid", 32'(rsp_valid_o), 32'b1100);
    check("rr_c_check", 32'(rf_check_o), 32'b00);
    tick();
    tick();

    // Same id on slots 0 and 3; rr_ptr has wrapped to 0 so slot 0 takes port 0.
    req_id_i[0] = 2'd2;
    req_sd_i[0] = 4'd5;
    req_id_i[3] = 2'd2;
    req_sd_i[3] = 4'd6;
    req_valid_i = 4'b1001;
    sb_q.push_back('{0, RSP_BYPASS, 4'd0});
    sb_q.push_back('{3, RSP_IGNORE, 4'd0});
    tick();
    req_valid_i = '0;
    @(negedge clk_i);
    check("dup_check", 32'(rf_check_o), 32'b11);
    check("dup_port0_sd", 32'(rf_sd_o[0]), 32'd5);
    check("dup_port1_sd", 32'(rf_sd_o[1]), 32'd6);
    tick();
    @(negedge clk_i);
    check("dup_rsp_valid", 32'(rsp_valid_o), 32'b1001);
    tick();
    tick();

    for (int v = 0; v < 7; v++) begin
      single_req(vecs[v].slot, vecs[v].id, vecs[v].sd, vecs[v].typ, vecs[v].esd);
    end

    // Slot 0 holds its response while the others keep completing.
    rsp_ready_i[0] = 1'b0;
    req_valid_i[0] = 1'b1;
    req_id_i[0]    = 2'd0;
    req_sd_i[0]    = 4'd2;
    sb_q.push_back('{0, RSP_STORED, 4'd0});
    tick();
    tick();
    single_req(2'd1, 2'd1, 4'd1, RSP_STORED, 4'd0);
    single_req(2'd2, 2'd1, 4'd6, RSP_DONE,   4'd1);
    single_req(2'd3, 2'd2, 4'd3, RSP_STORED, 4'd0);
    @(negedge clk_i);
    check("bp_slot0_valid", 32'(rsp_valid_o[0]), 32'd1);
    check("bp_slot0_ready", 32'(req_ready_o[0]), 32'd0);
    check("bp_slot0_type", 32'(rsp_type_o[0]), 32'(RSP_STORED));
    tick();
    rsp_ready_i[0] = 1'b1;
    req_valid_i[0] = 1'b0;
    tick();
    @(negedge clk_i);
    check("bp_release_valid", 32'(rsp_valid_o[0]), 32'd0);
    check("bp_release_ready", 32'(req_ready_o[0]), 32'd1);
    tick();

    // Reset while slot 2 is pending drops it silently.
    req_valid_i[2] = 1'b1;
    req_id_i[2]    = 2'd1;
    req_sd_i[2]    = 4'd7;
    tick();
    req_valid_i[2] = 1'b0;
    @(negedge clk_i);
    check("mid_rst_pend_check", 32'(rf_check_o), 32'b01);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("mid_rst_ready", 32'(req_ready_o), 32'hf);
    check("mid_rst_rf_check", 32'(rf_check_o), 32'b00);
    tick();
    @(negedge clk_i);
    check("mid_rst_no_rsp", 32'(rsp_valid_o), 32'h0);
    tick();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
